// File: rtl/div_32_pkg.sv
// Shared definitions for the div_32 multicycle signed divider: FSM encodings,
// iteration count and the operand pair that overflows a signed 32-bit quotient.
package div_32_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam int          DIV_ITER  = 32;
    localparam logic [5:0]  DIV_LAST  = 6'(DIV_ITER - 1);
    localparam logic [31:0] DIV_OVF_A = 32'h8000_0000;
    localparam logic [31:0] DIV_OVF_B = 32'hFFFF_FFFF;

endpackage

// File: rtl/negate_32.sv
// Two's-complement negation: bitwise inversion followed by an increment.
module negate_32 (
    input  logic [31:0] a,
    output logic [31:0] y
);

    logic [31:0] a_inv;

    not_32 u_not (
        .a (a),
        .y (a_inv)
    );

    assign y = a_inv + 32'd1;

endmodule

// File: rtl/not_32.sv
// 32-bit bitwise inverter shared with the ALU datapath.
module not_32 (
    input  logic [31:0] a,
    output logic [31:0] y
);

    assign y = ~a;

endmodule

// File: rtl/div_32.sv
// Multicycle signed 32-bit restoring divider: one quotient bit per cycle on
// operand magnitudes, sign applied once at the end; exceptions skip RUN.
module div_32
    import div_32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    div_state_t  state, state_next;
    logic [31:0] dvd;        // dividend shifting out, quotient shifting in
    logic [31:0] divisor;
    logic [31:0] rem;
    logic [5:0]  count;
    logic        sign_q;
    logic        exc;

    logic [31:0] neg_a, neg_b, neg_q, abs_a, abs_b, not_divisor;
    logic [32:0] rem_shift, trial;
    logic        div_zero, overflow, start_exc;

    negate_32 u_neg_a (.a(data_operandA), .y(neg_a));
    negate_32 u_neg_b (.a(data_operandB), .y(neg_b));
    negate_32 u_neg_q (.a(dvd),           .y(neg_q));
    not_32    u_not_b (.a(divisor),       .y(not_divisor));

    // 0x80000000 stays 0x80000000, which read as unsigned is the correct 2^31.
    assign abs_a = data_operandA[31] ? neg_a : data_operandA;
    assign abs_b = data_operandB[31] ? neg_b : data_operandB;

    assign div_zero  = (data_operandB == '0);
    assign overflow  = (data_operandA == DIV_OVF_A) && (data_operandB == DIV_OVF_B);
    assign start_exc = div_zero || overflow;

    // Remainder stays below |B| <= 2^31, so the shifted value fits in 33 bits
    // and bit 32 of the trial is a reliable sign.
    assign rem_shift = {rem, dvd[31]};
    assign trial     = rem_shift + {1'b1, not_divisor} + 33'd1;

    assign busy = (state != DIV_IDLE) || data_resultRDY;

    always_ff @(posedge clock) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (reset) state <= DIV_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned,
        // which would infer a latch.
        state_next = state;
        if (ctrl_DIV) begin
            state_next = start_exc ? DIV_DONE : DIV_RUN;
        end else begin
            case (state)
                DIV_RUN:  if (count == DIV_LAST) state_next = DIV_DONE;
                DIV_DONE: state_next = DIV_IDLE;
                default:  state_next = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dvd            <= '0;
            divisor        <= '0;
            rem            <= '0;
            count          <= '0;
            sign_q         <= 1'b0;
            exc            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_DIV) begin
                // Exceptions preload the final quotient so DONE needs no special case.
                divisor <= abs_b;
                rem     <= '0;
                count   <= '0;
                exc     <= start_exc;
                sign_q  <= start_exc ? 1'b0 : (data_operandA[31] ^ data_operandB[31]);
                dvd     <= div_zero ? '0 : (overflow ? DIV_OVF_A : abs_a);
            end else begin
                case (state)
                    DIV_RUN: begin
                        rem   <= trial[32] ? rem_shift[31:0] : trial[31:0];
                        dvd   <= {dvd[30:0], ~trial[32]};
                        count <= count + 6'd1;
                    end
                    DIV_DONE: begin
                        data_result    <= sign_q ? neg_q : dvd;
                        data_exception <= exc;
                        data_resultRDY <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_32.sv
// Directed self-checking bench for div_32: latency, signs, exceptions,
// abort by restart, mid-operation reset and back-to-back starts.
module tb_div_32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int errors = 0;
    int checks = 0;

    div_32 #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Caller is at a negedge; the capture edge is the next posedge.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Counts edges after capture until data_resultRDY is seen at a negedge.
    task automatic wait_rdy(output int cycles);
        cycles = 0;
        while (cycles < 60) begin
            @(posedge clock);
            cycles++;
            @(negedge clock);
            if (data_resultRDY) break;
        end
        if (!data_resultRDY) cycles = 99;
    endtask

    task automatic run_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input int lat, input logic [31:0] q, input logic e);
        int cyc;
        @(negedge clock);
        start(a, b);
        wait_rdy(cyc);
        check({tag, "_lat"}, 32'(cyc), 32'(lat));
        check({tag, "_q"}, data_result, q);
        check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, e});
        check({tag, "_busy_rdy"}, {31'd0, busy}, 32'd1);
        @(negedge clock);
        check({tag, "_rdy_1cyc"}, {31'd0, data_resultRDY}, 32'd0);
        check({tag, "_hold"}, data_result, q);
    endtask

    initial begin
        int cyc;
        int rdy_seen;

        repeat (3) @(negedge clock);
        check("rst_result", data_result, 32'd0);
        check("rst_exc", {31'd0, data_exception}, 32'd0);
        check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        run_case("pos", 32'd100, 32'd7, 33, 32'd14, 1'b0);
        run_case("negA", 32'hFFFF_FF9C, 32'd7, 33, 32'hFFFF_FFF2, 1'b0);
        run_case("negAB", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, 32'd3, 1'b0);
        run_case("min_by_1", 32'h8000_0000, 32'd1, 33, 32'h8000_0000, 1'b0);
        run_case("min_by_2", 32'h8000_0000, 32'd2, 33, 32'hC000_0000, 1'b0);
        run_case("div0", 32'd7, 32'd0, 1, 32'd0, 1'b1);
        run_case("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b1);
        run_case("after_exc", 32'd50, 32'hFFFF_FFFB, 33, 32'hFFFF_FFF6, 1'b0);

        // Restart mid-run: the aborted division must never report.
        @(negedge clock);
        start(32'd100, 32'd7);
        check("abort_busy", {31'd0, busy}, 32'd1);
        rdy_seen = 0;
        repeat (9) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        start(32'h7FFF_FFFF, 32'd1);
        wait_rdy(cyc);
        check("abort_lat", 32'(cyc), 32'd33);
        check("abort_q", data_result, 32'h7FFF_FFFF);
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        check("abort_single_rdy", 32'(rdy_seen), 32'd0);

        // Reset mid-run clears everything and suppresses completion.
        @(negedge clock);
        start(32'd100, 32'd7);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_result", data_result, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_exc", {31'd0, data_exception}, 32'd0);
        reset = 1'b0;
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        check("mid_rst_no_rdy", 32'(rdy_seen), 32'd0);
        run_case("post_rst", 32'd9, 32'd3, 33, 32'd3, 1'b0);

        // Back-to-back: new start issued in the completion cycle.
        @(negedge clock);
        start(32'd1000, 32'd10);
        wait_rdy(cyc);
        check("b2b_lat1", 32'(cyc), 32'd33);
        check("b2b_q1", data_result, 32'd100);
        start(32'd6, 32'd4);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_rdy(cyc);
        check("b2b_lat2", 32'(cyc), 32'd33);
        check("b2b_q2", data_result, 32'd1);
        check("b2b_exc2", {31'd0, data_exception}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
